led_pattern_seq: RTL

- Drives the five Icestick LEDs with selectable animated patterns.
- A raw push-button input is synchronised, debounced and edge-detected; each accepted press advances the display mode.
- A prescaler derives the animation step rate from the 12 MHz CLK.
- Registered LED outputs connect straight to the top-level LED1..LED5 pins.

---
 rtl/led_pattern_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//   Drives the five Icestick LEDs with an animated pattern chosen by a push
//   button. The raw button is synchronised, debounced and edge-detected. Each
//   accepted press advances the display mode CHASE -> BOUNCE -> BLINK -> OFF
//   -> CHASE. A prescaler turns CLK into the animation step rate.
//
// Parameters
//   STEP_DIV         CLK cycles per animation step (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable synced cycles to accept a BTN change (>= 2)
//
// Ports
//   CLK        in   system clock (12 MHz)
//   RST        in   asynchronous reset, active-high
//   BTN        in   raw push-button, active-high, asynchronous to CLK
//   LED1..LED5 out  registered pattern bits 0..4 (LED1 = bit0)
//   MODE       out  current mode: 0 CHASE, 1 BOUNCE, 2 BLINK, 3 OFF
//                   (this is the mode FSM state register itself)
//
// BTN has no handshake. A press is a one-cycle pulse, taken on the cycle
// after the debounced level rises. Releases never produce a pulse.
module led_pattern_seq #(
    parameter int STEP_DIV        = 1200000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic       LED5,
    output logic [1:0] MODE
);

    localparam int PW = $clog2(STEP_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] STEP_LAST = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    // ---------------- button front end ----------------
    logic          sync1_q, sync2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_level_q, db_level_d;
    logic          db_level_dly_q;
    logic          press;

    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        // The counter only runs while the synced input disagrees with the
        // accepted level. Any return to agreement clears it, so short glitches
        // can never be accepted.
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press = db_level_q & ~db_level_dly_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_cnt_q       <= '0;
            db_level_q     <= 1'b0;
            db_level_dly_q <= 1'b0;
        end else begin
            sync1_q        <= BTN;
            sync2_q        <= sync1_q;
            db_cnt_q       <= db_cnt_d;
            db_level_q     <= db_level_d;
            db_level_dly_q <= db_level_q;
        end
    end

    // ---------------- mode FSM and pattern ----------------
    mode_e         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    pos_q, pos_d;
    logic          dir_up_q, dir_up_d;
    logic [4:0]    leds_q, leds_d;
    logic          step;

    assign step = (presc_q == STEP_LAST);

    always_comb begin
        mode_d   = mode_q;
        presc_d  = presc_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        leds_d   = leds_q;

        if (press) begin
            // A press takes priority over a coincident step. The pattern restarts
            // from its initial state and that step is dropped.
            unique case (mode_q)
                MODE_CHASE:  mode_d = MODE_BOUNCE;
                MODE_BOUNCE: mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_OFF;
                default:     mode_d = MODE_CHASE;
            endcase
            presc_d  = '0;
            pos_d    = 3'd0;
            dir_up_d = 1'b1;
            unique case (mode_d)
                MODE_BLINK: leds_d = 5'b11111;
                MODE_OFF:   leds_d = 5'b00000;
                default:    leds_d = 5'b00001;
            endcase
        end else if (mode_q == MODE_OFF) begin
            presc_d = '0;
            leds_d  = 5'b00000;
        end else begin
            presc_d = step ? '0 : presc_q + 1'b1;
            if (step) begin
                unique case (mode_q)
                    MODE_CHASE: leds_d = {leds_q[3:0], leds_q[4]};
                    MODE_BOUNCE: begin
                        // Reverse at the ends without repeating the end
                        // position: 0,1,2,3,4,3,2,1,0,1,...
                        if (dir_up_q) begin
                            if (pos_q == 3'd4) begin
                                pos_d    = 3'd3;
                                dir_up_d = 1'b0;
                            end else begin
                                pos_d = pos_q + 3'd1;
                            end
                        end else begin
                            if (pos_q == 3'd0) begin
                                pos_d    = 3'd1;
                                dir_up_d = 1'b1;
                            end else begin
                                pos_d = pos_q - 3'd1;
                            end
                        end
                        leds_d = 5'b00001 << pos_d;
                    end
                    default: leds_d = ~leds_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q   <= MODE_CHASE;
            presc_q  <= '0;
            pos_q    <= 3'd0;
            dir_up_q <= 1'b1;
            leds_q   <= 5'b00001;
        end else begin
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            leds_q   <= leds_d;
        end
    end

    assign LED1 = leds_q[0];
    assign LED2 = leds_q[1];
    assign LED3 = leds_q[2];
    assign LED4 = leds_q[3];
    assign LED5 = leds_q[4];
    assign MODE = mode_q;

endmodule
